comp_sample_sequencer: RTL



---
 rtl/comp_sample_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/comp_sample_sequencer.sv
// Comparator-bank sampler: 2-flop sync, interval sampling, debounce, commit of code + popcount.
// Optional peak-hold of the committed popcount when PEAK_HOLD_EN is defined.
module comp_sample_sequencer #(
  parameter int SAMPLE_DIV = 1000,
  parameter int STABLE_CNT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [4:0] comps_raw,
`ifdef PEAK_HOLD_EN
  input  logic       peak_clr,
  output logic [2:0] peak,
`endif
  output logic [4:0] comps_out,
  output logic [2:0] count,
  output logic       upd
);

  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST   = DW'(SAMPLE_DIV - 1);
  localparam logic [3:0]    STABLE_MAX = 4'(STABLE_CNT);

  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, COMMIT} state_t;

  state_t        state_reg;
  logic [4:0]    sync1_reg;
  logic [4:0]    sync_reg;
  logic [4:0]    cand_reg;
  logic [3:0]    stable_reg;
  logic [DW-1:0] divider_reg;
  logic [3:0]    stable_next;
  logic          commit_go;

  function automatic logic [2:0] popcount(input logic [4:0] v);
    logic [2:0] acc;
    acc = '0;
    for (int i = 0; i < 5; i++) acc = acc + {2'b00, v[i]};
    return acc;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      sync_reg  <= '0;
    end else begin
      sync1_reg <= comps_raw;
      sync_reg  <= sync1_reg;
    end
  end

  // Debounce result of the sample taken this cycle, used only in SAMPLE.
  always_comb begin
    stable_next = 4'd1;
    if (sync_reg == cand_reg)
      stable_next = (stable_reg >= STABLE_MAX) ? STABLE_MAX : stable_reg + 4'd1;
    commit_go = (stable_next == STABLE_MAX) && (sync_reg != comps_out);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cand_reg    <= '0;
      stable_reg  <= '0;
      divider_reg <= '0;
      comps_out   <= '0;
      count       <= '0;
      upd         <= 1'b0;
    end else begin
      upd <= 1'b0;
      if (!en) begin
        // A commit already in flight still lands so the display stays coherent.
        if (state_reg == COMMIT) begin
          comps_out <= cand_reg;
          count     <= popcount(cand_reg);
          upd       <= 1'b1;
        end
        state_reg   <= IDLE;
        divider_reg <= '0;
        stable_reg  <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            divider_reg <= '0;
            state_reg   <= WAIT;
          end
          WAIT: begin
            if (divider_reg == DIV_LAST) begin
              divider_reg <= '0;
              state_reg   <= SAMPLE;
            end else begin
              divider_reg <= divider_reg + 1'b1;
            end
          end
          SAMPLE: begin
            cand_reg   <= sync_reg;
            stable_reg <= stable_next;
            state_reg  <= commit_go ? COMMIT : WAIT;
          end
          COMMIT: begin
            comps_out <= cand_reg;
            count     <= popcount(cand_reg);
            upd       <= 1'b1;
            state_reg <= WAIT;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

`ifdef PEAK_HOLD_EN
  logic [2:0] commit_cnt;
  assign commit_cnt = popcount(cand_reg);

  // On a coincident clear the freshly committed count takes precedence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak <= '0;
    end else if (state_reg == COMMIT) begin
      if (peak_clr || commit_cnt > peak) peak <= commit_cnt;
    end else if (peak_clr) begin
      peak <= count;
    end
  end
`endif

endmodule
